// File: rtl/rc5_tx_scheduler.sv
// rc5_tx_scheduler: round-robin RC-5 frame builder and Manchester transmitter for two requesters.
// Define RC5_CARRIER_EN to gate mark half-bits with a 50% carrier; otherwise ir_out is the baseband envelope.
module rc5_tx_scheduler #(
  parameter int HALF_BIT_CYCLES = 88900,
  parameter int FRAME_CYCLES    = 11379000,
  parameter int CARRIER_DIV     = 1389
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [4:0] addr0,
  input  logic [4:0] addr1,
  input  logic [5:0] cmd0,
  input  logic [5:0] cmd1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       toggle,
  output logic       ir_out
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic owner, winner, decide, load, handover, hb_last, send_done, frame_end, env;
  logic [13:0] frame;
  logic [4:0] hb_idx;
  logic [31:0] hb_cnt, ftimer;
  if (FRAME_CYCLES < 28 * HALF_BIT_CYCLES || CARRIER_DIV < 1) begin : g_bad_cfg
    $error("rc5_tx_scheduler: invalid timing parameters");
  end
  // with at least one request, the non-owner wins if it asks, else the owner keeps it
  assign winner = req[~owner] ? ~owner : owner;
  assign hb_last = hb_cnt == HALF_BIT_CYCLES - 1;
  assign send_done = state == SEND && hb_last && hb_idx == 5'd27;
  assign frame_end = ftimer == FRAME_CYCLES - 1;
  always_comb begin
    decide = state == IDLE || ((state == GAP || send_done) && frame_end);
    load = decide && req != 2'b00;
    handover = load && (state == IDLE || winner != owner);
    state_n = load ? SEND : decide ? IDLE : send_done ? GAP : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b1;
      toggle <= 1'b0;
      grant  <= 2'b00;
      frame  <= '0;
      hb_idx <= '0;
      hb_cnt <= '0;
      ftimer <= '0;
    end else begin
      state <= state_n;
      grant <= handover ? (winner ? 2'b10 : 2'b01) : 2'b00;
      if (load) begin
        owner  <= winner;
        toggle <= toggle ^ handover;
        frame  <= {2'b11, toggle ^ handover, winner ? addr1 : addr0, winner ? cmd1 : cmd0};
      end
      hb_cnt <= (state == SEND && !hb_last) ? hb_cnt + 32'd1 : '0;
      hb_idx <= (state == SEND && hb_last) ? (send_done ? '0 : hb_idx + 5'd1) : hb_idx;
      ftimer <= (load || frame_end || state == IDLE) ? '0 : ftimer + 32'd1;
    end
  // bit 1 is space-then-mark, so the envelope is high when the bit equals the half index
  assign env = ~(frame[4'd13 - hb_idx[4:1]] ^ hb_idx[0]);
  assign busy = state != IDLE;
`ifdef RC5_CARRIER_EN
  logic car_ph;
  logic [31:0] car_cnt;
  always_ff @(posedge clk)
    if (rst || load || (state == SEND && hb_last)) begin
      car_ph  <= 1'b1;
      car_cnt <= '0;
    end else begin
      car_ph  <= (car_cnt == CARRIER_DIV - 1) ? ~car_ph : car_ph;
      car_cnt <= (car_cnt == CARRIER_DIV - 1) ? '0 : car_cnt + 32'd1;
    end
  assign ir_out = state == SEND && env && car_ph;
`else
  assign ir_out = state == SEND && env;
`endif
endmodule

// File: tb/tb_rc5_tx_scheduler.sv
// tb_rc5_tx_scheduler: directed vectors and multi-frame sequences for rc5_tx_scheduler.
module tb_rc5_tx_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [5:0] cmd0 = '0, cmd1 = '0;
  logic [1:0] grant;
  logic busy, toggle, ir_out;
  int checks = 0, failures = 0, cyc = 0;
  logic [27:0] v;
  typedef struct {
    logic [1:0]  req;
    logic [4:0]  a;
    logic [5:0]  c;
    logic [1:0]  grant;
    logic        tog;
    logic [13:0] frame;
  } vec_t;
  vec_t tbl[5];
  rc5_tx_scheduler #(.HALF_BIT_CYCLES(4), .FRAME_CYCLES(150), .CARRIER_DIV(2)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1), .cmd0(cmd0), .cmd1(cmd1),
    .grant(grant), .busy(busy), .toggle(toggle), .ir_out(ir_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic go(input int n);
    while (cyc < n) tick();
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic start(input logic [1:0] r);
    req = r;
    tick();
    cyc = 0;
  endtask
  // samples one full frame starting at the current frame cycle; optionally drops req mid-frame
  task automatic capture(output logic [27:0] s, input int drop_at);
    for (int i = 0; i < 112; i++) begin
      if (i == drop_at) req = 2'b00;
      if (i % 4 == 1) s[27 - i / 4] = ir_out;
      tick();
    end
  endtask
  function automatic logic [27:0] manch(input logic [13:0] f);
    logic [27:0] r;
    for (int i = 0; i < 14; i++) begin
      r[27 - 2 * i] = ~f[13 - i];
      r[26 - 2 * i] = f[13 - i];
    end
    return r;
  endfunction
  initial begin
    tbl[0] = '{2'b01, 5'h05, 6'h0C, 2'b01, 1'b1, 14'b11_1_00101_001100};
    tbl[1] = '{2'b10, 5'h1F, 6'h3F, 2'b10, 1'b0, 14'b11_0_11111_111111};
    tbl[2] = '{2'b01, 5'h00, 6'h00, 2'b01, 1'b1, 14'b11_1_00000_000000};
    tbl[3] = '{2'b10, 5'h0A, 6'h15, 2'b10, 1'b0, 14'b11_0_01010_010101};
    tbl[4] = '{2'b11, 5'h13, 6'h2A, 2'b01, 1'b1, 14'b11_1_10011_101010};
    do_reset();
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 0);
    chk("reset_toggle", toggle, 0);
    chk("reset_ir", ir_out, 0);
    foreach (tbl[k]) begin
      addr0 = tbl[k].grant[1] ? ~tbl[k].a : tbl[k].a;
      addr1 = tbl[k].grant[1] ? tbl[k].a : ~tbl[k].a;
      cmd0  = tbl[k].grant[1] ? ~tbl[k].c : tbl[k].c;
      cmd1  = tbl[k].grant[1] ? tbl[k].c : ~tbl[k].c;
      start(tbl[k].req);
      req = 2'b00;
      chk($sformatf("vec%0d_grant", k), grant, tbl[k].grant);
      chk($sformatf("vec%0d_toggle", k), toggle, tbl[k].tog);
      chk($sformatf("vec%0d_busy", k), busy, 1);
      capture(v, -1);
      chk($sformatf("vec%0d_frame", k), v, manch(tbl[k].frame));
      go(149);
      chk($sformatf("vec%0d_busy149", k), busy, 1);
      tick();
      chk($sformatf("vec%0d_idle150", k), busy, 0);
    end
    // hold: repeats every 150 cycles, one grant, constant toggle, addr/cmd re-latched
    do_reset();
    addr0 = 5'h05;
    cmd0 = 6'h0C;
    start(2'b01);
    chk("hold_grant0", grant, 2'b01);
    tick();
    chk("hold_grant_pulse", grant, 2'b00);
    cyc = 0;
    @(negedge clk);
    capture(v, -1);
    cyc = 0;
    do_reset();
    start(2'b01);
    capture(v, -1);
    chk("hold_frame1", v, manch(14'b11_1_00101_001100));
    cmd0 = 6'h21;
    go(150);
    chk("hold_grant150", grant, 2'b00);
    chk("hold_toggle150", toggle, 1);
    chk("hold_busy150", busy, 1);
    capture(v, -1);
    chk("hold_frame2", v, manch(14'b11_1_00101_100001));
    go(300);
    chk("hold_grant300", grant, 2'b00);
    chk("hold_toggle300", toggle, 1);
    go(304);
    chk("hold_mark304", ir_out, 1);
    req = 2'b00;
    go(449);
    chk("hold_busy449", busy, 1);
    tick();
    chk("hold_idle450", busy, 0);
    // contention: alternating owners
    do_reset();
    addr0 = 5'h05;
    cmd0 = 6'h0C;
    addr1 = 5'h1A;
    cmd1 = 6'h33;
    start(2'b11);
    chk("cont_grant0", grant, 2'b01);
    chk("cont_toggle0", toggle, 1);
    go(150);
    chk("cont_grant150", grant, 2'b10);
    chk("cont_toggle150", toggle, 0);
    capture(v, -1);
    chk("cont_frame2", v, manch(14'b11_0_11010_110011));
    go(300);
    chk("cont_grant300", grant, 2'b01);
    chk("cont_toggle300", toggle, 1);
    req = 2'b00;
    go(450);
    chk("cont_idle450", busy, 0);
    // release at half-bit 10
    do_reset();
    addr0 = 5'h05;
    cmd0 = 6'h0C;
    start(2'b01);
    capture(v, 40);
    chk("rel_frame", v, manch(14'b11_1_00101_001100));
    go(149);
    chk("rel_busy149", busy, 1);
    tick();
    chk("rel_idle150", busy, 0);
    start(2'b01);
    req = 2'b00;
    chk("rel_toggle_new", toggle, 0);
    chk("rel_grant_new", grant, 2'b01);
    go(151);
    // reset at half-bit 15 (A0=1, second half is a mark)
    start(2'b01);
    go(60);
    chk("rstmid_mark60", ir_out, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_ir", ir_out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_toggle", toggle, 0);
    rst = 1'b0;
    start(2'b01);
    req = 2'b00;
    chk("rstmid_toggle_new", toggle, 1);
    chk("rstmid_grant_new", grant, 2'b01);
    go(151);
`ifdef RC5_CARRIER_EN
    begin
      logic [7:0] exp_c;
      exp_c = 8'b0000_1100;
      do_reset();
      start(2'b01);
      req = 2'b00;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("carrier_c%0d", i), ir_out, exp_c[7 - i]);
        tick();
      end
      go(151);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
